// File: rtl/hpdmc_wr_sequencer.sv
// hpdmc_wr_sequencer
// Write-burst sequencer for the DDR write datapath. It accepts a write command,
// waits out the write latency, and then drives the DQS preamble, BURST data
// cycles and the postamble into the paired DDR output registers. It also pops
// the write-data FIFO and owns the DQ/DQS output enables.
//
// Ports:
//   i_sys_clk, i_sys_rst        clock, asynchronous active-high reset
//   i_write_req / o_ready       command handshake (accept = req & ready)
//   o_fetch                     pop one word from the write-data FIFO
//   i_wdata/i_wmask/i_wdata_valid  FIFO word (upper half = rising edge)
//   o_dq_d0/d1, o_dm_d0/d1      rising/falling-edge data and mask
//   o_dqs_d0/d1                 rising/falling-edge DQS value
//   o_dq_oe, o_dqs_oe           output enables
//   o_busy                      not idle
//   o_underflow, i_underflow_clr  sticky FIFO-empty-on-fetch flag and clear
module hpdmc_wr_sequencer #(
  parameter int DW    = 16,
  parameter int WL    = 2,
  parameter int BURST = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_write_req,
  output logic                  o_ready,
  output logic                  o_fetch,
  input  logic [2*DW-1:0]       i_wdata,
  input  logic [2*DW/8-1:0]     i_wmask,
  input  logic                  i_wdata_valid,
  output logic [DW-1:0]         o_dq_d0,
  output logic [DW-1:0]         o_dq_d1,
  output logic [DW/8-1:0]       o_dm_d0,
  output logic [DW/8-1:0]       o_dm_d1,
  output logic                  o_dqs_d0,
  output logic                  o_dqs_d1,
  output logic                  o_dq_oe,
  output logic                  o_dqs_oe,
  output logic                  o_busy,
  output logic                  o_underflow,
  input  logic                  i_underflow_clr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_PRE  = 3'd2,
    S_DATA = 3'd3,
    S_POST = 3'd4
  } state_t;

  localparam int WCW = (WL > 2) ? $clog2(WL) : 1;
  localparam int BCW = $clog2(BURST);
  localparam int MW  = 2*DW/8;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WL >= 2) ? (WL - 2) : 0);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);
  // With WL = 1 the preamble directly follows the accept cycle.
  localparam state_t S_START = (WL == 1) ? S_PRE : S_WAIT;

  state_t               r_state;
  state_t               w_next;
  logic [WCW-1:0]       r_wcnt;
  logic [BCW-1:0]       r_bcnt;
  logic                 w_ready;
  logic                 w_fetch;
  logic                 w_accept;
  logic                 w_dqs_oe_nx;
  logic                 w_dq_oe_nx;
  logic                 w_dqs_d0_nx;
  logic                 w_busy_nx;
  logic [2*DW-1:0]      w_dq_nx;
  logic [MW-1:0]        w_dm_nx;
  logic                 r_dq_oe;
  logic                 r_dqs_oe;
  logic                 r_dqs_d0;
  logic                 r_dqs_d1;
  logic                 r_busy;
  logic                 r_underflow;
  logic [2*DW-1:0]      r_dq;
  logic [MW-1:0]        r_dm;

  assign w_accept = i_write_req & w_ready;

  // State register with the latency and beat counters.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= {WCW{1'b0}};
      r_bcnt  <= {BCW{1'b0}};
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + WCW'(1);
      end else begin
        r_wcnt <= {WCW{1'b0}};
      end
      // The beat counter only wraps at the last beat; no partial bursts.
      if ((r_state == S_DATA) && (r_bcnt != BEAT_LAST)) begin
        r_bcnt <= r_bcnt + BCW'(1);
      end else begin
        r_bcnt <= {BCW{1'b0}};
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_accept ? S_START : S_IDLE;
      S_WAIT: w_next = (r_wcnt == WAIT_LAST) ? S_PRE : S_WAIT;
      S_PRE:  w_next = S_DATA;
      S_DATA: w_next = (r_bcnt == BEAT_LAST) ? S_POST : S_DATA;
      // A command accepted during the postamble restarts the timeline.
      S_POST: w_next = w_accept ? S_START : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Current-state decode for the unregistered handshake outputs.
  always_comb begin
    w_ready = 1'b0;
    w_fetch = 1'b0;
    case (r_state)
      S_IDLE: w_ready = 1'b1;
      S_POST: w_ready = 1'b1;
      S_PRE:  w_fetch = 1'b1;
      // The last data cycle needs no fetch: its word was fetched one cycle earlier.
      S_DATA: w_fetch = (r_bcnt != BEAT_LAST);
      default: begin
        w_ready = 1'b0;
        w_fetch = 1'b0;
      end
    endcase
  end

  // Values the output registers take on the next edge, decoded from the next state.
  always_comb begin
    w_dqs_oe_nx = (w_next == S_PRE) || (w_next == S_DATA) || (w_next == S_POST);
    w_dq_oe_nx  = (w_next == S_DATA);
    w_dqs_d0_nx = (w_next == S_DATA);
    w_busy_nx   = (w_next != S_IDLE);
    // An empty FIFO on a fetch produces a fully masked zero beat.
    if (w_fetch && i_wdata_valid) begin
      w_dq_nx = i_wdata;
      w_dm_nx = i_wmask;
    end else begin
      w_dq_nx = {(2*DW){1'b0}};
      w_dm_nx = {MW{1'b1}};
    end
  end

  // Registered outputs, forced to bus-safe values by reset.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_dq_oe     <= 1'b0;
      r_dqs_oe    <= 1'b0;
      r_dqs_d0    <= 1'b0;
      r_dqs_d1    <= 1'b0;
      r_busy      <= 1'b0;
      r_underflow <= 1'b0;
      r_dq        <= {(2*DW){1'b0}};
      r_dm        <= {MW{1'b1}};
    end else begin
      r_dq_oe  <= w_dq_oe_nx;
      r_dqs_oe <= w_dqs_oe_nx;
      r_dqs_d0 <= w_dqs_d0_nx;
      r_dqs_d1 <= 1'b0;
      r_busy   <= w_busy_nx;
      r_dq     <= w_dq_nx;
      r_dm     <= w_dm_nx;
      // A new underflow takes priority over a simultaneous clear.
      if (w_fetch && !i_wdata_valid) begin
        r_underflow <= 1'b1;
      end else if (i_underflow_clr) begin
        r_underflow <= 1'b0;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end

  assign o_ready     = w_ready;
  assign o_fetch     = w_fetch;
  assign o_dq_d0     = r_dq[2*DW-1:DW];
  assign o_dq_d1     = r_dq[DW-1:0];
  assign o_dm_d0     = r_dm[MW-1:MW/2];
  assign o_dm_d1     = r_dm[MW/2-1:0];
  assign o_dqs_d0    = r_dqs_d0;
  assign o_dqs_d1    = r_dqs_d1;
  assign o_dq_oe     = r_dq_oe;
  assign o_dqs_oe    = r_dqs_oe;
  assign o_busy      = r_busy;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_hpdmc_wr_sequencer.sv
// Testbench for hpdmc_wr_sequencer: per-cycle scoreboard against a timeline
// model for WL=2/BURST=4, plus a short table check of a WL=1/BURST=2 instance.
module tb_hpdmc_wr_sequencer;

  localparam int DW    = 16;
  localparam int WL    = 2;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance signals.
  logic        i_write_req, i_wdata_valid, i_underflow_clr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wmask;
  logic        o_ready, o_fetch, o_dqs_d0, o_dqs_d1, o_dq_oe, o_dqs_oe, o_busy, o_underflow;
  logic [15:0] o_dq_d0, o_dq_d1;
  logic [1:0]  o_dm_d0, o_dm_d1;

  // Second instance (WL=1, BURST=2) signals.
  logic        req2;
  logic        rdy2, fetch2, dqs0_2, dqs1_2, dqoe2, dqsoe2, busy2, uf2;
  logic [15:0] dq0_2, dq1_2;
  logic [1:0]  dm0_2, dm1_2;

  hpdmc_wr_sequencer #(.DW(DW), .WL(WL), .BURST(BURST)) u_dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_write_req(i_write_req), .o_ready(o_ready),
    .o_fetch(o_fetch), .i_wdata(i_wdata), .i_wmask(i_wmask), .i_wdata_valid(i_wdata_valid),
    .o_dq_d0(o_dq_d0), .o_dq_d1(o_dq_d1), .o_dm_d0(o_dm_d0), .o_dm_d1(o_dm_d1),
    .o_dqs_d0(o_dqs_d0), .o_dqs_d1(o_dqs_d1), .o_dq_oe(o_dq_oe), .o_dqs_oe(o_dqs_oe),
    .o_busy(o_busy), .o_underflow(o_underflow), .i_underflow_clr(i_underflow_clr)
  );

  hpdmc_wr_sequencer #(.DW(16), .WL(1), .BURST(2)) u_dut2 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_write_req(req2), .o_ready(rdy2),
    .o_fetch(fetch2), .i_wdata(32'hCAFE_BEEF), .i_wmask(4'h0), .i_wdata_valid(1'b1),
    .o_dq_d0(dq0_2), .o_dq_d1(dq1_2), .o_dm_d0(dm0_2), .o_dm_d1(dm1_2),
    .o_dqs_d0(dqs0_2), .o_dqs_d1(dqs1_2), .o_dq_oe(dqoe2), .o_dqs_oe(dqsoe2),
    .o_busy(busy2), .o_underflow(uf2), .i_underflow_clr(1'b0)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  ctl;   // ready fetch busy dq_oe dqs_oe dqs_d0 dqs_d1 underflow
    logic [31:0] dq;
    logic [3:0]  dm;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Bench-side state of the stimulus and timeline model.
  int          cyc = 0;
  int          acc_q[$];
  int          pending = 0;
  logic        clr_req = 1'b0;
  logic [31:0] nx_dq = 32'h0;
  logic [3:0]  nx_dm = 4'hF;
  logic        exp_uf = 1'b0;
  logic [31:0] fifo_d[$];
  logic [3:0]  fifo_m[$];
  int          fetch_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Phase of cycle c from the most recent accept before it:
  // 0 IDLE, 1 WAIT, 2 PRE, 3 DATA (beat), 4 POST.
  function automatic int phase_of(input int c, output int beat);
    int a = -1;
    int k;
    beat = 0;
    foreach (acc_q[i]) if (acc_q[i] < c) a = acc_q[i];
    if (a < 0) return 0;
    k = c - a;
    if (k < WL) return 1;
    if (k == WL) return 2;
    if (k <= WL + BURST) begin
      beat = k - WL - 1;
      return 3;
    end
    if (k == WL + BURST + 1) return 4;
    return 0;
  endfunction

  // Drive one cycle and push its expected outputs.
  task automatic step();
    int   ph, beat;
    logic e_ready, e_fetch, v;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    ph      = phase_of(cyc, beat);
    e_ready = (ph == 0) || (ph == 4);
    e_fetch = (ph == 2) || ((ph == 3) && (beat <= BURST - 2));
    i_write_req = (pending > 0);
    if ((pending > 0) && e_ready) begin
      acc_q.push_back(cyc);
      pending--;
    end
    v = (fifo_d.size() > 0);
    i_wdata_valid   = v;
    i_wdata         = v ? fifo_d[0] : 32'h0;
    i_wmask         = v ? fifo_m[0] : 4'h0;
    i_underflow_clr = clr_req;
    e.cyc = cyc;
    e.ctl = {e_ready, e_fetch, (ph != 0), (ph == 3), (ph >= 2), (ph == 3), 1'b0, exp_uf};
    e.dq  = nx_dq;
    e.dm  = nx_dm;
    sb_q.push_back(e);
    if (e_fetch && v) begin
      nx_dq = fifo_d[0];
      nx_dm = fifo_m[0];
    end else begin
      nx_dq = 32'h0;
      nx_dm = 4'hF;
    end
    if (e_fetch && !v) exp_uf = 1'b1;
    else if (clr_req)  exp_uf = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [31:0] d, input logic [3:0] m);
    fifo_d.push_back(d);
    fifo_m.push_back(m);
  endtask

  // Write-data FIFO: pops only a word that was actually presented.
  always @(posedge clk) begin
    if (o_fetch) fetch_cnt <= fetch_cnt + 1;
    if (o_fetch && i_wdata_valid && (fifo_d.size() > 0)) begin
      void'(fifo_d.pop_front());
      void'(fifo_m.pop_front());
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq($sformatf("ctl@%0d", mon_e.cyc),
               {o_ready, o_fetch, o_busy, o_dq_oe, o_dqs_oe, o_dqs_d0, o_dqs_d1, o_underflow}, mon_e.ctl);
      check_eq($sformatf("dq@%0d", mon_e.cyc), {o_dq_d0, o_dq_d1}, mon_e.dq);
      check_eq($sformatf("dm@%0d", mon_e.cyc), {o_dm_d0, o_dm_d1}, mon_e.dm);
    end
  end

  initial begin
    int          f0;
    logic [5:0]  t_dqs_oe, t_dq_oe, t_fetch, t_ready;
    rst = 1'b1;
    i_write_req = 1'b0; i_wdata_valid = 1'b0; i_underflow_clr = 1'b0;
    i_wdata = 32'h0; i_wmask = 4'h0; req2 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_state", {o_ready, o_fetch, o_busy, o_dq_oe, o_dqs_oe, o_dqs_d0, o_dqs_d1, o_underflow},
             8'b1000_0000);
    check_eq("rst_dq", {o_dq_d0, o_dq_d1, o_dm_d0, o_dm_d1}, {32'h0, 4'hF});
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps(2);

    // Single burst with the reference data words.
    load(32'hAAAA5555, 4'h0); load(32'h11112222, 4'h0);
    load(32'h33334444, 4'h0); load(32'h66667777, 4'h0);
    f0 = fetch_cnt;
    pending = 1;
    steps(10);
    check_eq("single_fetches", 64'(fetch_cnt - f0), 64'd4);

    // Back-to-back: second request held and accepted in POST.
    for (int i = 0; i < 8; i++) load($urandom(), 4'($urandom_range(0, 15)));
    f0 = fetch_cnt;
    pending = 2;
    steps(17);
    check_eq("b2b_fetches", 64'(fetch_cnt - f0), 64'd8);

    // Underflow on the third fetch (cycle 4 after accept), then clear.
    load(32'h0102_0304, 4'h0); load(32'h0506_0708, 4'h5);
    pending = 1;
    steps(5);
    load(32'h090A_0B0C, 4'hA); load(32'h0D0E_0F10, 4'h0);
    steps(3);
    clr_req = 1'b1;
    steps(3);
    fifo_d.delete(); fifo_m.delete();

    // Empty FIFO for the whole burst, clear asserted on the first underflow: set wins.
    pending = 1;
    steps(2);
    clr_req = 1'b1;
    steps(7);
    clr_req = 1'b1;
    steps(2);

    // Reset in DATA cycle 4.
    load(32'h1234_5678, 4'h0); load(32'h9ABC_DEF0, 4'h3);
    load(32'h0F0F_F0F0, 4'h0); load(32'h5A5A_A5A5, 4'hC);
    pending = 1;
    steps(5);
    sb_q.delete();
    rst = 1'b1;
    #1;
    check_eq("midrst_oe", {o_dq_oe, o_dqs_oe, o_busy, o_ready}, 4'b0001);
    check_eq("midrst_dq", {o_dq_d0, o_dq_d1, o_dm_d0, o_dm_d1, o_dqs_d0}, {32'h0, 4'hF, 1'b0});
    acc_q.delete(); fifo_d.delete(); fifo_m.delete();
    nx_dq = 32'h0; nx_dm = 4'hF; exp_uf = 1'b0; pending = 0;
    i_write_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    load(32'hDEAD_BEEF, 4'h9); load(32'hFEED_F00D, 4'h0);
    load(32'h0BAD_C0DE, 4'h6); load(32'h7777_8888, 4'h0);
    pending = 1;
    steps(11);

    // WL=1, BURST=2 instance: IDLE, PRE, DATA, DATA, POST, IDLE.
    t_dqs_oe = 6'b011110;
    t_dq_oe  = 6'b001100;
    t_fetch  = 6'b000110;
    t_ready  = 6'b110001;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      req2 = (k == 0);
      @(negedge clk);
      check_eq($sformatf("wl1_ctl@%0d", k), {dqsoe2, dqoe2, fetch2, rdy2, dqs0_2},
               {t_dqs_oe[k], t_dq_oe[k], t_fetch[k], t_ready[k], t_dq_oe[k]});
      check_eq($sformatf("wl1_dq@%0d", k), {dq0_2, dq1_2},
               t_dq_oe[k] ? 64'hCAFE_BEEF : 64'h0);
    end

    @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdmc_wr_sequencer.md
Name: hpdmc_wr_sequencer

Overview:
Write-burst sequencer for the 16-bit DDR datapath. It accepts write commands from the HPDMC command scheduler and counts the write latency. It then drives the DQS preamble, data beats and postamble into the paired DDR output registers, and pulls write data and byte masks from the write-data FIFO. It owns the DQ and DQS output enables, so it is the only block that turns the DDR data bus around.

Parameters:
DW, 16, DDR data width in bits; a multiple of 8.
WL, 2, sys_clk cycles from command accept to the preamble cycle; WL >= 1.
BURST, 4, data cycles per burst; each cycle carries two DDR beats; BURST >= 2.

Ports:
sys_clk  in  1  system clock; the DDR output registers use it and its inverse.
sys_rst  in  1  asynchronous, active-high reset.
write_req  in  1  scheduler issues a write command this cycle.
ready  out  1  sequencer can accept a command; a command is accepted on write_req & ready.
fetch  out  1  pops one word from the write-data FIFO this cycle.
wdata  in  2*DW  FIFO word; upper half goes to the rising edge, lower half to the falling edge.
wmask  in  2*DW/8  byte masks, same split as wdata; 1 = byte masked.
wdata_valid  in  1  FIFO word is valid (FIFO not empty).
dq_d0, dq_d1  out  DW each  rising-edge / falling-edge DQ data to the output registers.
dm_d0, dm_d1  out  DW/8 each  rising-edge / falling-edge data mask to the output registers.
dqs_d0, dqs_d1  out  1 each  rising-edge / falling-edge DQS value.
dq_oe  out  1  DQ/DM output enable.
dqs_oe  out  1  DQS output enable.
busy  out  1  sequencer is not in IDLE.
underflow  out  1  sticky: the FIFO was empty when a fetch was due.
underflow_clr  in  1  clears underflow.

Behaviour:
- Reset (asynchronous, takes effect even mid-burst):
  - state = IDLE; ready = 1.
  - dq_oe = dqs_oe = 0 immediately.
  - dq_d0/d1 = 0, dm_d0/d1 = all ones, dqs_d0/d1 = 0.
  - fetch = 0, busy = 0, underflow = 0.
- All outputs except fetch and ready are registered (Moore). fetch and ready decode the current state.
- States and outputs:
  - IDLE: no outputs active.
  - WAIT: counts WL-1 cycles.
  - PRE: dqs_oe = 1, dqs_d0 = dqs_d1 = 0.
  - DATA: BURST cycles; dq_oe = dqs_oe = 1; dqs_d0 = 1, dqs_d1 = 0.
  - POST: dqs_oe = 1, dqs_d0 = dqs_d1 = 0, dq_oe = 0.
- Timeline, with accept in cycle 0:
  - WAIT occupies cycles 1..WL-1; it is skipped when WL = 1.
  - PRE in cycle WL.
  - DATA in cycles WL+1 .. WL+BURST.
  - POST in cycle WL+BURST+1.
  - IDLE after that.
- ready = 1 in IDLE and in POST only.
  - Accept in POST restarts the timeline at cycle 0 (next state WAIT, or PRE if WL = 1).
  - dqs_oe follows the new state: it is 0 during WAIT and stays 1 when the next state is PRE.
- fetch = 1 in PRE and in DATA cycles 0..BURST-2, i.e. exactly BURST fetches per burst.
  - The word sampled on a fetch appears on dq_d*/dm_d* in the following cycle.
- Fetch with wdata_valid = 0:
  - The captured beat is data 0 and mask all ones.
  - underflow is set; the burst still completes with unchanged timing.
  - The FIFO must ignore the pop when empty.
- Outside DATA, dq_d* = 0 and dm_d* = all ones.
- underflow_clr clears underflow. If clear and a new underflow happen in the same cycle, set wins.
- write_req while ready = 0 is ignored; the scheduler must hold the request.
- The beat counter wraps only at BURST-1. No partial bursts.

Test Plan:
- Single burst, WL=2, BURST=4, accept at cycle 0 -> PRE at cycle 2; DATA cycles 3-6 with dqs_d0=1; POST at cycle 7; IDLE at cycle 8; fetch at cycles 2-5; dq_oe=1 only in cycles 3-6.
- Data mapping: FIFO words 0xAAAA5555, 0x11112222, 0x33334444, 0x66667777, masks 0 -> dq_d0/dq_d1 = AAAA/5555, 1111/2222, 3333/4444, 6666/7777 in cycles 3-6; dm_d* = 0.
- Back-to-back: second write_req held, accepted in POST (cycle 7) -> WAIT cycle 8, PRE cycle 9, DATA cycles 10-13; dqs_oe=0 only in cycle 8; 8 fetches total.
- Underflow: wdata_valid=0 at the fetch in cycle 4 -> cycle 5 shows dq=0, dm=2'b11 per edge; underflow=1 from cycle 5 until underflow_clr; burst timing unchanged.
- Reset mid-burst: assert sys_rst in DATA cycle 4 -> dq_oe, dqs_oe, busy drop before the next edge; ready=1; a fresh accept after release follows the nominal timeline.
- WL=1, BURST=2 -> accept at cycle 0, PRE at cycle 1, DATA cycles 2-3, POST at cycle 4; no WAIT state.
